// File: rtl/udp_frame_initiator_pkg.sv
// rtl/udp_frame_initiator_pkg.sv - shared states, header layout and default addressing for the UDP frame initiator
package udp_frame_initiator_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_REQ,
        ST_WAIT_RX,
        ST_H0,
        ST_H1,
        ST_H2,
        ST_DATA,
        ST_DISCARD,
        ST_CHECK
    } state_t;

    localparam int          HEAD_WORDS         = 3;
    localparam logic [31:0] DEF_MSGID          = 32'h7469_7277;
    localparam logic [31:0] DEF_PEER_IP        = {8'd192, 8'd168, 8'd10, 8'd14};
    localparam logic [15:0] DEF_PEER_PORT      = 16'd2390;
    localparam logic [15:0] DEF_LOCAL_PORT     = 16'd11451;

    // States in which the reply deadline is running.
    function automatic logic reply_window(input state_t s);
        return s inside {ST_WAIT_RX, ST_H0, ST_H1, ST_H2, ST_DATA, ST_DISCARD, ST_CHECK};
    endfunction

endpackage

// File: rtl/udp_byte_shifter.sv
// rtl/udp_byte_shifter.sv - parallel-load MSB-first byte serializer/deserializer with saturating byte counter
module udp_byte_shifter #(
    parameter int WIDTH = 80
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clear,
    input  logic             shift,
    input  logic [7:0]       shift_in,
    output logic [WIDTH-1:0] data,
    output logic [7:0]       count
);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            count <= 8'd0;
        end else if (load) begin
            data  <= load_data;
            count <= 8'd0;
        end else if (clear) begin
            data  <= '0;
            count <= 8'd0;
        end else if (shift) begin
            data <= {data[WIDTH-9:0], shift_in};
            if (count != 8'hFF) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/udp_frame_initiator.sv
// rtl/udp_frame_initiator.sv - periodic UDP command sender that validates and latches the peer's reply
module udp_frame_initiator
    import udp_frame_initiator_pkg::*;
#(
    parameter int          BUFFER_SIZE   = 80,
    parameter logic [31:0] MSGID         = DEF_MSGID,
    parameter logic [31:0] PEER_IP       = DEF_PEER_IP,
    parameter logic [15:0] PEER_PORT     = DEF_PEER_PORT,
    parameter logic [15:0] LOCAL_PORT    = DEF_LOCAL_PORT,
    parameter logic [31:0] PERIOD        = 32'd50000,
    parameter logic [31:0] REPLY_TIMEOUT = 32'd25000
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic [BUFFER_SIZE-33:0] tx_data,
    output logic [BUFFER_SIZE-33:0] rx_data,
    output logic                    pkg_timeout,
    output logic                    cycle_done,
    output logic [31:0]             tx_ip_o,
    output logic [15:0]             tx_dst_port_o,
    output logic                    tx_req_o,
    input  logic                    tx_req_rdy_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_data_av_o,
    input  logic                    rx_head_av_i,
    input  logic [31:0]             rx_head_i,
    output logic                    rx_head_rdy_o,
    input  logic                    rx_data_av_i,
    input  logic [7:0]              rx_data_i
);

    localparam int         PW          = BUFFER_SIZE - 32;
    localparam logic [7:0] FRAME_BYTES = 8'(BUFFER_SIZE / 8);
    localparam logic [7:0] LAST_BYTE   = 8'(BUFFER_SIZE / 8 - 1);
    localparam logic [1:0] HEAD_SKIP   = 2'(HEAD_WORDS);

    state_t                 state, state_nx;
    logic [31:0]            period_cnt, reply_cnt;
    logic [1:0]             head_skip;
    logic                   ip_ok;
    logic [BUFFER_SIZE-1:0] tx_frame, rx_frame;
    logic [7:0]             tx_count, rx_count;
    logic                   period_wrap, reply_expired, head_free;
    logic                   stray_accept, reply_accept, head_match, frame_ok;
    logic                   frame_valid, timeout_hit;
    logic                   tx_load, tx_shift, rx_clear, rx_shift;
    logic                   unused_tx;

    assign period_wrap   = (period_cnt == PERIOD - 32'd1);
    assign reply_expired = (reply_cnt >= REPLY_TIMEOUT);
    // After any header accept the next HEAD_WORDS clocks carry its words, not a new header.
    assign head_free     = (head_skip == 2'd0);
    assign stray_accept  = rx_head_av_i && head_free && (state inside {ST_IDLE, ST_LOAD, ST_SEND, ST_REQ});
    assign reply_accept  = rx_head_av_i && head_free && (state == ST_WAIT_RX) && !reply_expired;
    assign rx_head_rdy_o = stray_accept || reply_accept;
    assign head_match    = ip_ok && (rx_head_i[31:16] == PEER_PORT) && (rx_head_i[15:0] == LOCAL_PORT);
    assign frame_ok      = (rx_count == FRAME_BYTES) && (rx_frame[BUFFER_SIZE-1 -: 32] == MSGID);

    assign tx_load       = (state == ST_LOAD) && tx_req_rdy_i;
    assign tx_shift      = (state == ST_SEND);
    assign rx_clear      = (state == ST_H2);
    assign rx_shift      = (state == ST_DATA) && rx_data_av_i;

    assign tx_data_av_o  = (state == ST_SEND);
    assign tx_data_o     = tx_data_av_o ? tx_frame[BUFFER_SIZE-1 -: 8] : 8'h00;
    assign tx_req_o      = (state == ST_REQ) && tx_req_rdy_i;
    assign tx_ip_o       = PEER_IP;
    assign tx_dst_port_o = PEER_PORT;
    assign unused_tx     = ^tx_frame[BUFFER_SIZE-9:0];

    udp_byte_shifter #(.WIDTH(BUFFER_SIZE)) u_tx_shifter (
        .sysclk    (sysclk),
        .rst       (rst),
        .load      (tx_load),
        .load_data ({MSGID, tx_data}),
        .clear     (1'b0),
        .shift     (tx_shift),
        .shift_in  (8'h00),
        .data      (tx_frame),
        .count     (tx_count)
    );

    udp_byte_shifter #(.WIDTH(BUFFER_SIZE)) u_rx_shifter (
        .sysclk    (sysclk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .clear     (rx_clear),
        .shift     (rx_shift),
        .shift_in  (rx_data_i),
        .data      (rx_frame),
        .count     (rx_count)
    );

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        frame_valid = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE:    if (period_wrap) state_nx = ST_LOAD;
            ST_LOAD:    if (tx_req_rdy_i) state_nx = ST_SEND;
            ST_SEND:    if (tx_count == LAST_BYTE) state_nx = ST_REQ;
            ST_REQ:     if (tx_req_rdy_i) state_nx = ST_WAIT_RX;
            ST_WAIT_RX: begin
                if (reply_expired) begin
                    timeout_hit = 1'b1;
                    state_nx    = ST_IDLE;
                end else if (reply_accept) begin
                    state_nx = ST_H0;
                end
            end
            ST_H0, ST_H1, ST_H2: begin
                if (reply_expired) begin
                    timeout_hit = 1'b1;
                    state_nx    = ST_IDLE;
                end else if (state == ST_H0) begin
                    state_nx = ST_H1;
                end else if (state == ST_H1) begin
                    state_nx = ST_H2;
                end else begin
                    state_nx = head_match ? ST_DATA : ST_DISCARD;
                end
            end
            // A reply already in flight is finished before the deadline is judged.
            ST_DATA:    if (!rx_data_av_i && rx_count != 8'd0) state_nx = ST_CHECK;
            ST_DISCARD: begin
                if (reply_expired) begin
                    timeout_hit = 1'b1;
                    state_nx    = ST_IDLE;
                end else if (!rx_data_av_i) begin
                    state_nx = ST_WAIT_RX;
                end
            end
            ST_CHECK: begin
                if (frame_ok) begin
                    frame_valid = 1'b1;
                    state_nx    = ST_IDLE;
                end else if (reply_expired) begin
                    timeout_hit = 1'b1;
                    state_nx    = ST_IDLE;
                end else begin
                    state_nx = ST_WAIT_RX;
                end
            end
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            period_cnt  <= 32'd0;
            reply_cnt   <= 32'd0;
            head_skip   <= 2'd0;
            ip_ok       <= 1'b0;
            pkg_timeout <= 1'b1;
            cycle_done  <= 1'b0;
            rx_data     <= '0;
        end else begin
            period_cnt <= period_wrap ? 32'd0 : period_cnt + 32'd1;
            if (tx_req_o) begin
                reply_cnt <= 32'd0;
            end else if (reply_window(state) && reply_cnt != '1) begin
                reply_cnt <= reply_cnt + 32'd1;
            end
            if (rx_head_rdy_o) begin
                head_skip <= HEAD_SKIP;
            end else if (!head_free) begin
                head_skip <= head_skip - 2'd1;
            end
            if (state == ST_H0) begin
                ip_ok <= (rx_head_i == PEER_IP);
            end
            if (timeout_hit) begin
                pkg_timeout <= 1'b1;
            end else if (frame_valid) begin
                pkg_timeout <= 1'b0;
            end
            cycle_done <= frame_valid;
            if (frame_valid) begin
                rx_data <= rx_frame[PW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_udp_frame_initiator.sv
// tb/tb_udp_frame_initiator.sv - directed scoreboard bench for udp_frame_initiator
module tb_udp_frame_initiator;

    localparam int          BS        = 80;
    localparam int          NB        = BS / 8;
    localparam logic [31:0] T_PERIOD  = 32'd100;
    localparam logic [31:0] T_TIMEOUT = 32'd300;
    localparam logic [31:0] MSG       = 32'h7469_7277;
    localparam logic [31:0] PIP       = {8'd192, 8'd168, 8'd10, 8'd14};
    localparam logic [15:0] PPORT     = 16'd2390;
    localparam logic [15:0] LPORT     = 16'd11451;

    logic          sysclk = 1'b0;
    logic          rst;
    logic [BS-33:0] tx_data;
    logic [BS-33:0] rx_data;
    logic          pkg_timeout, cycle_done;
    logic [31:0]   tx_ip_o;
    logic [15:0]   tx_dst_port_o;
    logic          tx_req_o, tx_req_rdy_i;
    logic [7:0]    tx_data_o;
    logic          tx_data_av_o;
    logic          rx_head_av_i;
    logic [31:0]   rx_head_i;
    logic          rx_head_rdy_o;
    logic          rx_data_av_i;
    logic [7:0]    rx_data_i;

    int checks = 0;
    int errors = 0;
    int cyc;
    int run_len = 0;
    int tx_total = 0;
    int first_byte_cyc = 0;
    int req_cyc = 0;
    logic frame_done = 1'b0;
    logic prev_cd = 1'b0;
    logic last_accept_av = 1'b0;
    logic [7:0]  tx_q[$];
    logic [63:0] rx_q[$];

    udp_frame_initiator #(
        .BUFFER_SIZE   (BS),
        .PERIOD        (T_PERIOD),
        .REPLY_TIMEOUT (T_TIMEOUT)
    ) dut (
        .sysclk        (sysclk),
        .rst           (rst),
        .tx_data       (tx_data),
        .rx_data       (rx_data),
        .pkg_timeout   (pkg_timeout),
        .cycle_done    (cycle_done),
        .tx_ip_o       (tx_ip_o),
        .tx_dst_port_o (tx_dst_port_o),
        .tx_req_o      (tx_req_o),
        .tx_req_rdy_i  (tx_req_rdy_i),
        .tx_data_o     (tx_data_o),
        .tx_data_av_o  (tx_data_av_o),
        .rx_head_av_i  (rx_head_av_i),
        .rx_head_i     (rx_head_i),
        .rx_head_rdy_o (rx_head_rdy_o),
        .rx_data_av_i  (rx_data_av_i),
        .rx_data_i     (rx_data_i)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TX scoreboard: each streamed byte pops the next expected byte.
    always @(negedge sysclk) begin
        logic [8:0] exp_b;
        if (rst) begin
            run_len    = 0;
            frame_done = 1'b0;
        end else begin
            if (tx_data_av_o) begin
                if (run_len == 0) first_byte_cyc = cyc;
                run_len++;
                tx_total++;
                exp_b = (tx_q.size() != 0) ? {1'b0, tx_q.pop_front()} : 9'h1FF;
                check("tx_byte", {55'd0, 1'b0, tx_data_o}, {55'd0, exp_b});
            end else if (run_len != 0) begin
                check("tx_run_len", run_len, NB);
                run_len    = 0;
                frame_done = 1'b1;
            end
            if (tx_req_o) begin
                check("tx_req_after_frame", frame_done, 1);
                frame_done = 1'b0;
                req_cyc    = cyc;
            end
        end
    end

    // RX scoreboard: each cycle_done pops the payload expected to be latched.
    always @(negedge sysclk) begin
        logic [63:0] exp_r;
        if (!rst && cycle_done) begin
            check("cycle_done_pulse", prev_cd, 0);
            exp_r = (rx_q.size() != 0) ? rx_q.pop_front() : 64'hFFFF_0000_0000_0000;
            check("rx_data_latched", {16'd0, rx_data}, exp_r);
        end
        prev_cd = cycle_done;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [BS-33:0] p);
        logic [BS-1:0] f;
        f = {MSG, p};
        for (int i = 0; i < NB; i++) tx_q.push_back(f[BS-1-8*i -: 8]);
    endtask

    task automatic wait_req(input int bound);
        logic got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge sysclk);
            got = tx_req_o;
        end
        check("req_seen", got, 1);
        @(posedge sysclk); #1;
        tx_req_rdy_i = 1'b0;
    endtask

    task automatic wait_tx_start(input int bound);
        logic got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge sysclk);
            got = tx_data_av_o;
        end
        check("tx_start_seen", got, 1);
    endtask

    task automatic wait_rx_done(input int bound);
        for (int i = 0; i < bound && rx_q.size() != 0; i++) @(negedge sysclk);
        check("reply_latched", rx_q.size(), 0);
    endtask

    task automatic send_reply(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                              input logic [95:0] body, input int n);
        logic got;
        got = 1'b0;
        @(posedge sysclk); #1;
        rx_head_av_i = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge sysclk);
            got = rx_head_rdy_o;
            if (got) last_accept_av = tx_data_av_o;
        end
        check("head_accept", got, 1);
        @(posedge sysclk); #1;
        rx_head_av_i = 1'b0;
        rx_head_i    = ip;
        @(posedge sysclk); #1;
        rx_head_i    = 32'h0;
        @(posedge sysclk); #1;
        rx_head_i    = {sp, dp};
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk); #1;
            rx_data_av_i = 1'b1;
            rx_data_i    = body[95-8*i -: 8];
        end
        @(posedge sysclk); #1;
        rx_data_av_i = 1'b0;
        rx_data_i    = 8'h00;
        rx_head_i    = 32'h0;
    endtask

    initial begin
        int base;
        int rel;
        int t_rise;
        logic got;
        rst          = 1'b1;
        tx_data      = 48'h0102_0304_0506;
        tx_req_rdy_i = 1'b0;
        rx_head_av_i = 1'b0;
        rx_head_i    = 32'h0;
        rx_data_av_i = 1'b0;
        rx_data_i    = 8'h00;

        repeat (3) @(posedge sysclk);
        #1;
        check("rst_pkg_timeout", pkg_timeout, 1);
        check("rst_cycle_done", cycle_done, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_av", tx_data_av_o, 0);
        check("rst_tx_req", tx_req_o, 0);
        check("rst_head_rdy", rx_head_rdy_o, 0);
        check("tx_ip", tx_ip_o, PIP);
        check("tx_dst_port", tx_dst_port_o, PPORT);
        rst = 1'b0;

        // 1: first frame after the first period wrap
        push_frame(48'h0102_0304_0506);
        tx_req_rdy_i = 1'b1;
        wait_req(250);
        check("first_byte_cycle", first_byte_cyc, 101);
        check("timeout_before_reply", pkg_timeout, 1);

        // 2: valid echo
        rx_q.push_back(64'h0000_A1A2_A3A4_A5A6);
        send_reply(PIP, PPORT, LPORT, {MSG, 48'hA1A2_A3A4_A5A6, 16'h0}, NB);
        wait_rx_done(50);
        check("timeout_cleared", pkg_timeout, 0);

        // 3: three invalid replies, then the deadline expires
        tx_data = 48'h3132_3334_3536;
        push_frame(tx_data);
        tx_req_rdy_i = 1'b1;
        wait_req(250);
        send_reply(PIP, PPORT, LPORT, {32'h7469_7278, 48'hBADB_ADBA_DBAD, 16'h0}, NB);
        send_reply(PIP, PPORT, LPORT, {MSG, 48'hCCCC_CCCC_CCCC, 16'h0}, NB - 1);
        send_reply(PIP, 16'd2391, LPORT, {MSG, 48'hDDDD_DDDD_DDDD, 16'h0}, NB);
        check("bad_reply_rx_data", rx_data, 48'hA1A2_A3A4_A5A6);
        check("bad_reply_no_timeout_yet", pkg_timeout, 0);
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge sysclk);
            got = pkg_timeout;
        end
        t_rise = cyc;
        check("timeout_seen", got, 1);
        check("timeout_latency", ((t_rise - req_cyc) >= int'(T_TIMEOUT)) && ((t_rise - req_cyc) <= int'(T_TIMEOUT) + 3), 1);
        check("timeout_rx_data", rx_data, 48'hA1A2_A3A4_A5A6);
        tx_data = 48'h4142_4344_4546;
        push_frame(tx_data);
        tx_req_rdy_i = 1'b1;
        wait_req(250);
        rx_q.push_back(64'h0000_B1B2_B3B4_B5B6);
        send_reply(PIP, PPORT, LPORT, {MSG, 48'hB1B2_B3B4_B5B6, 16'h0}, NB);
        wait_rx_done(50);
        check("recover_timeout_cleared", pkg_timeout, 0);

        // 4: core stalls the load for 500 clocks
        tx_data = 48'hDEAD_BEEF_0011;
        base = tx_total;
        repeat (500) @(posedge sysclk);
        #1;
        check("stall_no_tx", tx_total, base);
        push_frame(tx_data);
        rel = cyc;
        tx_req_rdy_i = 1'b1;
        wait_req(50);
        check("release_latency", first_byte_cyc - rel, 1);
        rx_q.push_back(64'h0000_E1E2_E3E4_E5E6);
        send_reply(PIP, PPORT, LPORT, {MSG, 48'hE1E2_E3E4_E5E6, 16'h0}, NB);
        wait_rx_done(50);

        // 5: stray header while the frame is streaming
        tx_data = 48'h1112_1314_1516;
        push_frame(tx_data);
        tx_req_rdy_i = 1'b1;
        wait_tx_start(250);
        send_reply(PIP, PPORT, LPORT, {MSG, 48'h0, 16'h0}, 0);
        check("stray_during_send", last_accept_av, 1);
        wait_req(50);
        rx_q.push_back(64'h0000_C1C2_C3C4_C5C6);
        send_reply(PIP, PPORT, LPORT, {MSG, 48'hC1C2_C3C4_C5C6, 16'h0}, NB);
        wait_rx_done(50);

        // 6: reset in the middle of SEND
        tx_data = 48'h2122_2324_2526;
        push_frame(tx_data);
        tx_req_rdy_i = 1'b1;
        wait_tx_start(250);
        repeat (3) @(negedge sysclk);
        @(posedge sysclk); #1;
        rst = 1'b1;
        #1;
        check("midrst_tx_av", tx_data_av_o, 0);
        check("midrst_tx_data", tx_data_o, 0);
        check("midrst_tx_req", tx_req_o, 0);
        check("midrst_pkg_timeout", pkg_timeout, 1);
        check("midrst_rx_data", rx_data, 0);
        tx_q.delete();
        repeat (2) @(posedge sysclk);
        #1;
        rst = 1'b0;
        push_frame(tx_data);
        wait_req(250);
        check("post_rst_first_byte", first_byte_cyc, 101);
        rx_q.push_back(64'h0000_D1D2_D3D4_D5D6);
        send_reply(PIP, PPORT, LPORT, {MSG, 48'hD1D2_D3D4_D5D6, 16'h0}, NB);
        wait_rx_done(50);
        check("post_rst_timeout_cleared", pkg_timeout, 0);

        repeat (5) @(posedge sysclk);
        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
